// File: rtl/subtrator_pkg.sv
// Shared definitions for the serial subtractor.
// SUB_WIDTH : default operand/result width in bits
// state_t   : controller states
package subtrator_pkg;

   localparam int SUB_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIM  = 2'd2
   } state_t;

endpackage

// File: rtl/subtrator_completo.sv
// One-bit full subtractor, used as the single per-bit stage of the serial
// subtractor.
// a, b : operand bits
// bin  : borrow in
// d    : difference bit a - b - bin
// bout : borrow out
module subtrator_completo (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/subtrator_serial_4bits.sv
// Bit-serial ripple-borrow subtractor: diferenca = a - b - bin, one bit per
// clock, LSB first, using a single full-subtractor stage.
// clk        : clock, rising edge
// rst_n      : synchronous active-low reset
// start      : accepted only in IDLE; captures a, b, bin
// a, b, bin  : minuend, subtrahend, borrow in
// diferenca  : result, updated only when the last bit is resolved
// borrow_out : final borrow, updated together with diferenca
// busy       : high in CALC
// done       : one-cycle pulse in FIM
//
// state | meaning
// IDLE  | waiting for start, results held
// CALC  | resolving one bit per edge, WIDTH edges total
// FIM   | results valid, done pulse, back to IDLE next edge
module subtrator_serial_4bits
   import subtrator_pkg::*;
#(
   parameter int WIDTH = SUB_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic [WIDTH-1:0] diferenca,
   output logic             borrow_out,
   output logic             busy,
   output logic             done
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             brw_q, brw_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] dif_q, dif_d;
   logic             bout_q, bout_d;

   logic             stg_d;
   logic             stg_bout;

   // the one stage is time-shared across all bit positions via cnt_q
   subtrator_completo u_stage (
      .a    (a_q[cnt_q]),
      .b    (b_q[cnt_q]),
      .bin  (brw_q),
      .d    (stg_d),
      .bout (stg_bout)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      brw_d   = brw_q;
      res_d   = res_q;
      dif_d   = dif_q;
      bout_d  = bout_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               brw_d   = bin;
               res_d   = '0;
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            res_d[cnt_q] = stg_d;
            brw_d        = stg_bout;
            cnt_d        = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               // publish the complete word at once; partial bits never show
               dif_d   = res_d;
               bout_d  = stg_bout;
               cnt_d   = '0;
               state_d = FIM;
            end
         end
         FIM:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         brw_q   <= 1'b0;
         res_q   <= '0;
         dif_q   <= '0;
         bout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         brw_q   <= brw_d;
         res_q   <= res_d;
         dif_q   <= dif_d;
         bout_q  <= bout_d;
      end
   end

   assign diferenca  = dif_q;
   assign borrow_out = bout_q;
   assign busy       = (state_q == CALC);
   assign done       = (state_q == FIM);

endmodule
